// File: rtl/fc_in_feeder_if.sv
// Feeder bus: binarized feature vectors in, lane-parallel beats out to the MAC stage.
// The slave modport is the feeder's view; the master modport is the producer/consumer side.
interface fc_in_feeder_if #(
  parameter int NBEAT = 36,
  parameter int LANES = 3
);
  logic [NBEAT*LANES-1:0] feat_in;
  logic                   feat_valid;
  logic                   feat_ready;
  logic [LANES-1:0]       mac_in;
  logic                   mac_valid;
  logic                   mac_first;
  logic                   mac_last;
  logic [7:0]             frame_cnt;

  modport slave (
    input  feat_in, feat_valid,
    output feat_ready, mac_in, mac_valid, mac_first, mac_last, frame_cnt
  );

  modport master (
    output feat_in, feat_valid,
    input  feat_ready, mac_in, mac_valid, mac_first, mac_last, frame_cnt
  );
endinterface

// File: rtl/fc_in_feeder.sv
// Two-deep vector FIFO that serializes each buffered vector into NBEAT beats of LANES bits,
// streaming frames back-to-back. rst_n is an active-high synchronous reset despite its name.
module fc_in_feeder #(
  parameter int NBEAT = 36,
  parameter int LANES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  fc_in_feeder_if.slave      bus
);
  localparam int W  = NBEAT * LANES;
  localparam int KW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBEAT - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [W-1:0]     mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic [0:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LANES-1:0] mac_in_q, mac_in_d;
  logic             mac_valid_q, mac_valid_d;
  logic             mac_first_q, mac_first_d;
  logic             mac_last_q, mac_last_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             accept;
  logic             pop;

  // Lane l of beat k is vector bit l*NBEAT + NBEAT-1-k: each lane walks its slice MSB first.
  function automatic logic [LANES-1:0] beat_of(input logic [W-1:0] v, input logic [KW-1:0] k);
    logic [LANES-1:0] b;
    b = '0;
    for (int l = 0; l < LANES; l++) begin
      b[l] = v[IW'(l * NBEAT + NBEAT - 1 - int'(k))];
    end
    return b;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    accept      = bus.feat_valid & ready_q;
    pop         = (state_q == ST_STREAM) && (k_q == K_LAST);
    state_d     = state_q;
    k_d         = k_q;
    rd_ptr_d    = rd_ptr_q ^ pop;
    wr_ptr_d    = wr_ptr_q ^ accept;
    count_d     = count_q + {1'b0, accept} - {1'b0, pop};
    ready_d     = (count_d < 2'd2);
    frame_cnt_d = frame_cnt_q + 8'(pop);

    case (state_q)
      ST_IDLE: begin
        if (count_q != 2'd0) begin
          state_d = ST_STREAM;
          k_d     = '0;
        end
      end
      ST_STREAM: begin
        if (pop) begin
          // A second buffered vector starts on the very next beat; otherwise fall idle.
          k_d = '0;
          if (count_q != 2'd2) state_d = ST_IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    mac_in_d    = '0;
    mac_valid_d = 1'b0;
    mac_first_d = 1'b0;
    mac_last_d  = 1'b0;
    if (state_d == ST_STREAM) begin
      mac_in_d    = beat_of(mem_q[rd_ptr_d], k_d);
      mac_valid_d = 1'b1;
      mac_first_d = (k_d == '0);
      mac_last_d  = (k_d == K_LAST);
    end
  end

  // NOTE: the vector storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.feat_in;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      ready_q     <= 1'b0;
      state_q     <= ST_IDLE;
      k_q         <= '0;
      mac_in_q    <= '0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      state_q     <= state_d;
      k_q         <= k_d;
      mac_in_q    <= mac_in_d;
      mac_valid_q <= mac_valid_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.feat_ready = ready_q;
  assign bus.mac_in     = mac_in_q;
  assign bus.mac_valid  = mac_valid_q;
  assign bus.mac_first  = mac_first_q;
  assign bus.mac_last   = mac_last_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fc_in_feeder.sv
// Directed bench for fc_in_feeder: a table of single-frame lane-order vectors plus
// hand-written sequences for back-to-back, full-FIFO, mid-frame reset and counter wrap.
module tb_fc_in_feeder;
  localparam int NB = 36;
  localparam int LN = 3;
  localparam int W  = NB * LN;

  typedef struct {
    logic [W-1:0]  vec;
    int            k;
    logic [LN-1:0] exp_mac;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   dr_valid, dr_last, dr_first;
  int   dr_nz[$];

  fc_in_feeder_if #(.NBEAT(NB), .LANES(LN)) bus ();

  fc_in_feeder #(.NBEAT(NB), .LANES(LN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [W-1:0] bit_at(input int b);
    logic [W-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b1;
    bus.feat_valid = 1'b0;
    tick();
    check("rst_ready", bus.feat_ready, 0);
    check("rst_valid", bus.mac_valid, 0);
    check("rst_flags", {bus.mac_first, bus.mac_last}, 0);
    check("rst_mac_in", bus.mac_in, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    rst_n = 1'b0;
    tick();
    check("rst_release_ready", bus.feat_ready, 1);
  endtask

  // Offers v until it is taken; returns just after the accepting edge.
  task automatic push(input logic [W-1:0] v);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    bus.feat_in = v;
    bus.feat_valid = 1'b1;
    while (!acc && n < 500) begin
      acc = bus.feat_ready;
      tick();
      n++;
    end
    bus.feat_valid = 1'b0;
    if (!acc) fail("push_timeout");
  endtask

  // Waits for a stream to start, then records it until mac_valid drops.
  task automatic drain();
    int n;
    int idx;
    n = 0;
    idx = 0;
    dr_valid = 0;
    dr_last = 0;
    dr_first = 0;
    dr_nz.delete();
    while (!bus.mac_valid && n < 300) begin
      tick();
      n++;
    end
    if (!bus.mac_valid) begin
      fail("drain_start_timeout");
      return;
    end
    while (bus.mac_valid && idx < 2000) begin
      if (bus.mac_in != '0) dr_nz.push_back(idx);
      dr_last += int'(bus.mac_last);
      dr_first += int'(bus.mac_first);
      idx++;
      tick();
    end
    dr_valid = idx;
  endtask

  // Single frame from an empty, idle feeder: checks latency and collects all beats.
  task automatic run_frame(input logic [W-1:0] v, output logic [W-1:0] beats,
                           output logic [NB-1:0] f, output logic [NB-1:0] l);
    int gaps;
    gaps = 0;
    beats = '0;
    f = '0;
    l = '0;
    push(v);
    check("latency_not_yet_valid", bus.mac_valid, 0);
    tick();
    for (int k = 0; k < NB; k++) begin
      beats[k*LN +: LN] = bus.mac_in;
      f[k] = bus.mac_first;
      l[k] = bus.mac_last;
      if (!bus.mac_valid) gaps++;
      tick();
    end
    check("frame_gaps", gaps, 0);
    check("idle_after_frame", {bus.mac_valid, bus.mac_in}, 0);
  endtask

  initial begin
    vec_t         tbl[8];
    logic [W-1:0] beats, exp_word;
    logic [NB-1:0] f, l;
    logic [NB-1:0] exp_l;
    int           seen, cnt_before, cnt_after, n, vcount;

    bus.feat_in = '0;
    bus.feat_valid = 1'b0;

    tbl[0] = '{bit_at(0), 35, 3'b001};
    tbl[1] = '{bit_at(107) | bit_at(71) | bit_at(35), 0, 3'b111};
    tbl[2] = '{bit_at(106), 1, 3'b100};
    tbl[3] = '{bit_at(36), 35, 3'b010};
    tbl[4] = '{bit_at(72) | bit_at(0), 35, 3'b101};
    tbl[5] = '{bit_at(50), 21, 3'b010};
    tbl[6] = '{bit_at(80), 27, 3'b100};
    tbl[7] = '{bit_at(70) | bit_at(34), 1, 3'b011};

    exp_l = '0;
    exp_l[NB-1] = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_frame(tbl[i].vec, beats, f, l);
      exp_word = '0;
      exp_word[tbl[i].k*LN +: LN] = tbl[i].exp_mac;
      check($sformatf("vec%0d_beats", i), beats, exp_word);
      check($sformatf("vec%0d_first", i), f, 1);
      check($sformatf("vec%0d_last", i), l, exp_l);
      check($sformatf("vec%0d_frame_cnt", i), bus.frame_cnt, 1);
    end

    // Back-to-back: three vectors, second fills the FIFO, third waits for the first pop.
    do_reset();
    fork
      begin
        push(bit_at(107));
        check("b2b_ready_one_stored", bus.feat_ready, 1);
        push(bit_at(106));
        check("b2b_ready_full", bus.feat_ready, 0);
        push(bit_at(105));
      end
      drain();
    join
    check("b2b_valid_run", dr_valid, 108);
    check("b2b_lasts", dr_last, 3);
    check("b2b_firsts", dr_first, 3);
    check("b2b_frame_cnt", bus.frame_cnt, 3);
    check("b2b_nz_count", dr_nz.size(), 3);
    if (dr_nz.size() == 3) begin
      check("b2b_nz0", dr_nz[0], 0);
      check("b2b_nz1", dr_nz[1], 37);
      check("b2b_nz2", dr_nz[2], 74);
    end

    // Full FIFO: an all-ones vector offered while not ready must never reach mac_in.
    do_reset();
    push('0);
    push('0);
    check("full_ready_low", bus.feat_ready, 0);
    fork
      drain();
      begin
        bus.feat_in = '1;
        bus.feat_valid = 1'b1;
        repeat (10) tick();
        bus.feat_valid = 1'b0;
        bus.feat_in = '0;
      end
    join
    check("full_valid_run", dr_valid, 72);
    check("full_nz_beats", dr_nz.size(), 0);
    check("full_frame_cnt", bus.frame_cnt, 2);
    vcount = 0;
    repeat (40) begin
      if (bus.mac_valid) vcount++;
      tick();
    end
    check("full_no_extra_frame", vcount, 0);

    // Reset at beat 20 with a second vector buffered: everything is discarded.
    do_reset();
    push(bit_at(107));
    push(bit_at(0));
    repeat (20) tick();
    check("midrst_beat20_state", {bus.mac_valid, bus.mac_first, bus.mac_last}, 3'b100);
    rst_n = 1'b1;
    tick();
    check("midrst_valid", {bus.mac_valid, bus.mac_last}, 0);
    check("midrst_frame_cnt", bus.frame_cnt, 0);
    check("midrst_ready_low", bus.feat_ready, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_ready_high", bus.feat_ready, 1);
    vcount = 0;
    repeat (40) begin
      if (bus.mac_valid) vcount++;
      tick();
    end
    check("midrst_discarded", vcount, 0);
    run_frame(bit_at(107), beats, f, l);
    exp_word = '0;
    exp_word[2:0] = 3'b100;
    check("midrst_new_beats", beats, exp_word);
    check("midrst_new_first", f, 1);
    check("midrst_new_frame_cnt", bus.frame_cnt, 1);

    // Wrap: 256 frames streamed continuously bring frame_cnt back to 0.
    do_reset();
    seen = 0;
    cnt_before = -1;
    cnt_after = -1;
    fork
      begin
        for (int i = 0; i < 256; i++) push('0);
      end
      begin
        n = 0;
        while (seen < 256 && n < 12000) begin
          if (bus.mac_last) begin
            seen++;
            if (seen == 256) begin
              cnt_before = int'(bus.frame_cnt);
              tick();
              cnt_after = int'(bus.frame_cnt);
            end
          end
          if (seen < 256) tick();
          n++;
        end
      end
    join
    check("wrap_lasts", seen, 256);
    check("wrap_cnt_before", cnt_before, 255);
    check("wrap_cnt_after", cnt_after, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
